// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the multicycle multiply/divide unit.
package muldiv_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_dp.sv
// Magnitude shift-add / restoring-divide datapath with sign fix-up and HI/LO result registers.
module muldiv_dp
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             is_div_i,
  input  logic             step_i,
  input  logic             fix_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  // Magnitude is unsigned so the most negative operand maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mag_q;
  logic               div_q;
  logic               neg_res_q;
  logic               neg_rem_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     part_rem;
  logic [WIDTH-1:0]   sub_diff;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix;
  logic [WIDTH-1:0]   rem_fix;

  // acc holds {partial product, multiplier} for MULT and {partial remainder, dividend/quotient} for DIV.
  always_comb begin
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
    mul_next = {add_sum, acc_q[WIDTH-1:1]};
    part_rem = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    sub_diff = part_rem[WIDTH-1:0] - mag_q;
    if (part_rem >= {1'b0, mag_q}) begin
      div_next = {sub_diff, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {part_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
    prod_fix = neg_res_q ? -acc_q : acc_q;
    quot_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
    rem_fix  = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, (is_div_i ? magnitude(a_i) : magnitude(b_i))};
      mag_q <= is_div_i ? magnitude(b_i) : magnitude(a_i);
    end else if (step_i) begin
      acc_q <= div_q ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (load_i) begin
        div_q     <= is_div_i;
        neg_res_q <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
        neg_rem_q <= a_i[WIDTH-1];
      end
      if (fix_i) begin
        if (div_q) begin
          hi_q <= rem_fix;
          lo_q <= quot_fix;
        end else begin
          hi_q <= prod_fix[2*WIDTH-1:WIDTH];
          lo_q <= prod_fix[WIDTH-1:0];
        end
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_unit.sv
// Multicycle signed MULT/DIV unit: start arbitration, step counter and control FSM around muldiv_dp.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  muldiv_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic             load;
  logic             is_div;
  logic             step;
  logic             fix;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    load    = 1'b0;
    is_div  = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Multiply has priority; a divide by zero skips straight to DONE and leaves HI/LO alone.
        if (start_mult) begin
          load    = 1'b1;
          dz_d    = 1'b0;
          cnt_d   = '0;
          state_d = MULT;
        end else if (start_div) begin
          cnt_d = '0;
          if (b != '0) begin
            load    = 1'b1;
            is_div  = 1'b1;
            dz_d    = 1'b0;
            state_d = DIV;
          end else begin
            dz_d    = 1'b1;
            state_d = DONE;
          end
        end
      end
      MULT, DIV: begin
        step = 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = FIX;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FIX: begin
        fix     = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign div_zero = dz_q;

  muldiv_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk     (clk),
    .reset   (reset),
    .load_i  (load),
    .is_div_i(is_div),
    .step_i  (step),
    .fix_i   (fix),
    .a_i     (a),
    .b_i     (b),
    .hi_o    (hi),
    .lo_o    (lo)
  );

endmodule
